// File: rtl/sram_responder.sv
// Device-side emulation of one 32-bit asynchronous SRAM on the baseram/extram pins.
// Backed by on-chip memory that is cleared to INIT_VALUE after every reset.
module sram_responder #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          READ_LAT   = 1,
  parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] ram_addr,
  inout  wire  [31:0] ram_data,
  input  logic        ram_ce,
  input  logic        ram_oe,
  input  logic        ram_we,
  output logic        busy,
  output logic        conflict,
  output logic [15:0] write_count
);

  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {INIT, IDLE, WRITE, READ} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   init_ptr;

  logic                    s_ce_p0, s_oe_p0, s_we_p0, s_we_p1;
  logic [ADDR_WIDTH-1:0]   s_addr_p0;
  logic [DATA_W-1:0]       s_data_p0;

  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_W-1:0]       wr_data;

  logic [DATA_W-1:0]       mem [DEPTH];
  logic [DATA_W-1:0]       rd_p [1:READ_LAT];
  logic [READ_LAT:1]       vld_p;

  logic                    rd_req, wr_req, commit, mem_we, drive;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_W-1:0]       mem_wdata;

  // Upper address pins are deliberately ignored so addresses alias.
  if (ADDR_WIDTH < 20) begin : g_alias
    logic unused_addr_bits;
    assign unused_addr_bits = ^ram_addr[19:ADDR_WIDTH];
  end

  // Stage p0: pin sampling; control resets to the inactive (high) level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ce_p0 <= 1'b1;
      s_oe_p0 <= 1'b1;
      s_we_p0 <= 1'b1;
      s_we_p1 <= 1'b1;
    end else begin
      s_ce_p0 <= ram_ce;
      s_oe_p0 <= ram_oe;
      s_we_p0 <= ram_we;
      s_we_p1 <= s_we_p0;
    end
  end

  always_ff @(posedge clk) begin
    s_addr_p0 <= ram_addr[ADDR_WIDTH-1:0];
    s_data_p0 <= ram_data;
  end

  assign rd_req = (state != INIT) & ~s_ce_p0 & ~s_oe_p0 & s_we_p0;
  assign wr_req = ~s_ce_p0 & ~s_we_p0;
  // Inside WRITE the previous sample had ce and we low, so either rising ends the pulse.
  assign commit = (state == WRITE) & ((s_we_p0 & ~s_we_p1) | s_ce_p0);

  assign mem_we    = (state == INIT) | commit;
  assign mem_waddr = (state == INIT) ? init_ptr : wr_addr;
  assign mem_wdata = (state == INIT) ? INIT_VALUE : wr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INIT;
      busy        <= 1'b1;
      conflict    <= 1'b0;
      write_count <= '0;
      init_ptr    <= '0;
    end else begin
      if ((state != INIT) && !s_ce_p0 && !s_oe_p0 && !s_we_p0)
        conflict <= 1'b1;
      case (state)
        INIT: begin
          init_ptr <= init_ptr + ADDR_WIDTH'(1);
          if (init_ptr == '1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (wr_req)      state <= WRITE;
          else if (rd_req) state <= READ;
        end
        WRITE: begin
          if (commit) begin
            write_count <= write_count + 16'd1;
            state       <= IDLE;
          end
        end
        READ: begin
          if (wr_req)       state <= WRITE;
          else if (!rd_req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write latch: the last low sample before release wins
  always_ff @(posedge clk) begin
    if ((state != INIT) && wr_req) begin
      wr_addr <= s_addr_p0;
      wr_data <= s_data_p0;
    end
  end

  // Stage p1..pREAD_LAT: read pipeline; any non-read sample flushes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else begin
      vld_p[1] <= rd_req;
      for (int i = 2; i <= READ_LAT; i++)
        vld_p[i] <= vld_p[i-1] & rd_req;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
    rd_p[1] <= (commit && (wr_addr == s_addr_p0)) ? wr_data : mem[s_addr_p0];
    for (int i = 2; i <= READ_LAT; i++)
      rd_p[i] <= rd_p[i-1];
  end

  assign drive    = vld_p[READ_LAT] & rd_req;
  assign ram_data = drive ? rd_p[READ_LAT] : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: directed scenarios plus random traffic checked
// against an array model of the SRAM contents and write counter.
module tb_sram_responder;

  localparam int          AW    = 10;
  localparam int          RL    = 1;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] IV    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] ram_addr;
  logic        ram_ce, ram_oe, ram_we;
  logic        busy, conflict;
  logic [15:0] write_count;
  wire  [31:0] ram_data;
  logic        tb_drv;
  logic [31:0] tb_dout;

  int          n_pass, n_total;
  logic [31:0] model_mem [DEPTH];
  int unsigned model_wc;

  assign ram_data = tb_drv ? tb_dout : 32'bz;

  sram_responder #(.ADDR_WIDTH(AW), .READ_LAT(RL), .INIT_VALUE(IV)) dut (
    .clk(clk), .rst_n(rst_n), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_ce(ram_ce), .ram_oe(ram_oe), .ram_we(ram_we),
    .busy(busy), .conflict(conflict), .write_count(write_count)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_pins();
    ram_ce = 1'b1;
    ram_oe = 1'b1;
    ram_we = 1'b1;
    tb_drv = 1'b0;
  endtask

  task automatic model_init();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = IV;
    model_wc = 0;
  endtask

  task automatic wait_init(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (busy && cnt < 2000);
  endtask

  task automatic do_write(input logic [19:0] a, input logic [31:0] d, input int hold);
    ram_addr = a; tb_dout = d; tb_drv = 1'b1;
    ram_ce = 1'b0; ram_we = 1'b0; ram_oe = 1'b1;
    repeat (hold) step();
    idle_pins();
    step();
    step();
    model_mem[a[AW-1:0]] = d;
    model_wc++;
  endtask

  // Returns the bus before data is due, when it is due, and after release.
  task automatic do_read(input logic [19:0] a, output logic [31:0] early,
                         output logic [31:0] val, output logic [31:0] after);
    ram_addr = a; tb_drv = 1'b0;
    ram_ce = 1'b0; ram_oe = 1'b0; ram_we = 1'b1;
    step();
    early = ram_data;
    repeat (RL) step();
    val = ram_data;
    idle_pins();
    step();
    after = ram_data;
  endtask

  task automatic do_burst(input logic [19:0] addrs [$], output logic [31:0] got [$],
                          output logic [31:0] after);
    int n;
    n = addrs.size();
    got = {};
    tb_drv = 1'b0;
    ram_ce = 1'b0; ram_oe = 1'b0; ram_we = 1'b1;
    ram_addr = addrs[0];
    for (int s = 1; s <= n + RL; s++) begin
      step();
      if (s - 1 - RL >= 0) got.push_back(ram_data);
      if (s < n) ram_addr = addrs[s];
    end
    idle_pins();
    step();
    after = ram_data;
  endtask

  task automatic test_reset();
    int cnt;
    logic [31:0] e, v, af;
    repeat (3) step();
    n_total++; if (busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy); else n_pass++;
    n_total++; if (conflict !== 1'b0) $display("FAIL reset_conflict: got %b want 0", conflict); else n_pass++;
    n_total++; if (write_count !== 16'd0) $display("FAIL reset_wc: got %0d want 0", write_count); else n_pass++;
    rst_n = 1'b1;
    wait_init(cnt);
    n_total++; if (cnt != DEPTH) $display("FAIL init_cycles: got %0d want %0d", cnt, DEPTH); else n_pass++;
    do_read(20'h003FF, e, v, af);
    n_total++; if (v !== IV) $display("FAIL init_read_3ff: got %h want %h", v, IV); else n_pass++;
  endtask

  task automatic test_write_read();
    logic [31:0] e, v, af;
    do_write(20'h00012, 32'hDEADBEEF, 2);
    n_total++; if (write_count !== 16'(model_wc)) $display("FAIL wr_count: got %0d want %0d", write_count, model_wc); else n_pass++;
    do_read(20'h00012, e, v, af);
    n_total++; if (e === 32'hDEADBEEF) $display("FAIL rd_early_hiz: got %h want bus not driven", e); else n_pass++;
    n_total++; if (v !== 32'hDEADBEEF) $display("FAIL rd_data: got %h want DEADBEEF", v); else n_pass++;
    n_total++; if (af === 32'hDEADBEEF) $display("FAIL rd_after_hiz: got %h want bus not driven", af); else n_pass++;
  endtask

  task automatic test_alias();
    logic [31:0] e, v, af;
    do_write(20'h00412, 32'h12345678, 1);
    n_total++; if (write_count !== 16'(model_wc)) $display("FAIL alias_wc: got %0d want %0d", write_count, model_wc); else n_pass++;
    do_read(20'h00012, e, v, af);
    n_total++; if (v !== 32'h12345678) $display("FAIL alias_read: got %h want 12345678", v); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] e, v, af;
    ram_addr = 20'h00033; tb_dout = 32'h0BADF00D; tb_drv = 1'b1;
    ram_ce = 1'b0; ram_we = 1'b0; ram_oe = 1'b1;
    step();
    model_mem[10'h033] = 32'h0BADF00D;
    model_wc++;
    do_read(20'h00033, e, v, af);
    n_total++; if (v !== 32'h0BADF00D) $display("FAIL raw_forward: got %h want 0BADF00D", v); else n_pass++;
    n_total++; if (write_count !== 16'(model_wc)) $display("FAIL raw_wc: got %0d want %0d", write_count, model_wc); else n_pass++;
  endtask

  task automatic test_burst();
    logic [19:0] q [$];
    logic [31:0] got [$];
    logic [31:0] af;
    q = {};
    for (int k = 0; k < 4; k++) begin
      do_write(20'(k), 32'hA0 + 32'(k), 1);
      q.push_back(20'(k));
    end
    do_burst(q, got, af);
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (got[k] !== 32'hA0 + 32'(k)) $display("FAIL burst_%0d: got %h want %h", k, got[k], 32'hA0 + 32'(k));
      else n_pass++;
    end
    n_total++; if (af === 32'hA3) $display("FAIL burst_release: got %h want bus not driven", af); else n_pass++;
  endtask

  task automatic test_random();
    logic [19:0] a;
    logic [31:0] d, e, v, af, exp_v;
    logic [19:0] q [$];
    logic [31:0] got [$];
    int len;
    for (int it = 0; it < 40; it++) begin
      a = 20'($urandom);
      a[9:0] = 10'($urandom_range(0, 15));
      case ($urandom_range(0, 2))
        0: begin
          d = $urandom;
          do_write(a, d, int'($urandom_range(1, 3)));
        end
        1: begin
          exp_v = model_mem[a[AW-1:0]];
          do_read(a, e, v, af);
          n_total++; if (v !== exp_v) $display("FAIL rand_read it%0d: got %h want %h", it, v, exp_v); else n_pass++;
        end
        default: begin
          len = int'($urandom_range(2, 6));
          q = {};
          for (int k = 0; k < len; k++) begin
            a = 20'($urandom);
            a[9:0] = 10'($urandom_range(0, 15));
            q.push_back(a);
          end
          do_burst(q, got, af);
          for (int k = 0; k < len; k++) begin
            exp_v = model_mem[q[k][AW-1:0]];
            n_total++;
            if (got[k] !== exp_v) $display("FAIL rand_burst it%0d.%0d: got %h want %h", it, k, got[k], exp_v);
            else n_pass++;
          end
        end
      endcase
    end
    n_total++; if (write_count !== 16'(model_wc)) $display("FAIL rand_wc: got %0d want %0d", write_count, model_wc); else n_pass++;
  endtask

  task automatic test_conflict();
    logic [19:0] a;
    logic [31:0] d, e, v, af;
    int cnt;
    a = 20'h00155;
    d = 32'hC0FFEE01;
    ram_addr = a; tb_dout = d; tb_drv = 1'b1;
    ram_ce = 1'b0; ram_oe = 1'b0; ram_we = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step();
      n_total++; if (ram_data !== d) $display("FAIL conflict_bus s%0d: got %h want %h", s, ram_data, d); else n_pass++;
    end
    n_total++; if (conflict !== 1'b1) $display("FAIL conflict_set: got %b want 1", conflict); else n_pass++;
    idle_pins();
    step();
    step();
    model_mem[a[AW-1:0]] = d;
    model_wc++;
    n_total++; if (write_count !== 16'(model_wc)) $display("FAIL conflict_wc: got %0d want %0d", write_count, model_wc); else n_pass++;
    do_read(a, e, v, af);
    n_total++; if (v !== d) $display("FAIL conflict_data: got %h want %h", v, d); else n_pass++;
    n_total++; if (conflict !== 1'b1) $display("FAIL conflict_sticky: got %b want 1", conflict); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (conflict !== 1'b0) $display("FAIL conflict_clear: got %b want 0", conflict); else n_pass++;
    step();
    rst_n = 1'b1;
    model_init();
    wait_init(cnt);
    n_total++; if (cnt != DEPTH) $display("FAIL reinit_cycles: got %0d want %0d", cnt, DEPTH); else n_pass++;
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] e, v, af;
    int cnt;
    do_write(20'h002A0, 32'hCAFEF00D, 2);
    n_total++; if (write_count !== 16'(model_wc)) $display("FAIL mid_pre_wc: got %0d want %0d", write_count, model_wc); else n_pass++;
    ram_addr = 20'h002A0; tb_dout = 32'h11112222; tb_drv = 1'b1;
    ram_ce = 1'b0; ram_we = 1'b0; ram_oe = 1'b1;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    n_total++; if (busy !== 1'b1) $display("FAIL mid_busy: got %b want 1", busy); else n_pass++;
    n_total++; if (write_count !== 16'd0) $display("FAIL mid_wc_reset: got %0d want 0", write_count); else n_pass++;
    step();
    idle_pins();
    step();
    rst_n = 1'b1;
    model_init();
    // Write attempt while the clear is still running must be ignored.
    ram_addr = 20'h00077; tb_dout = 32'h99998888; tb_drv = 1'b1;
    ram_ce = 1'b0; ram_we = 1'b0; ram_oe = 1'b1;
    cnt = 0;
    repeat (3) begin step(); cnt++; end
    idle_pins();
    while (busy && cnt < 2000) begin step(); cnt++; end
    n_total++; if (cnt != DEPTH) $display("FAIL mid_init_cycles: got %0d want %0d", cnt, DEPTH); else n_pass++;
    n_total++; if (write_count !== 16'(model_wc)) $display("FAIL mid_wc: got %0d want %0d", write_count, model_wc); else n_pass++;
    do_read(20'h002A0, e, v, af);
    n_total++; if (v !== model_mem[10'h2A0]) $display("FAIL mid_loc: got %h want %h", v, model_mem[10'h2A0]); else n_pass++;
    do_read(20'h00077, e, v, af);
    n_total++; if (v !== model_mem[10'h077]) $display("FAIL init_ignore: got %h want %h", v, model_mem[10'h077]); else n_pass++;
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    rst_n    = 1'b0;
    ram_addr = '0;
    tb_dout  = '0;
    idle_pins();
    model_init();
    test_reset();
    test_write_read();
    test_alias();
    test_back_to_back();
    test_burst();
    test_random();
    test_conflict();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
